// File: rtl/pc_fetch_seq.sv
// Program-counter and fetch sequencer feeding the 4-bit instruction register.
// Define PC_CALL_STACK_EN to add call/ret with a 1-deep return register.
module pc_fetch_seq #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run,
   input  logic              stall,
   input  logic              exec_done,
   input  logic              jmp,
   input  logic              bz,
   input  logic              zero_flag,
   input  logic [ADDR_W-1:0] jmp_addr,
   input  logic              halt,
`ifdef PC_CALL_STACK_EN
   input  logic              call,
   input  logic              ret,
   output logic              stack_err,
`endif
   output logic [ADDR_W-1:0] pm_addr,
   output logic              ir_ce,
   output logic              fetch_valid,
   output logic              halted
);

   // state   | meaning
   // S_IDLE  | waiting for run
   // S_ADDR  | pm_addr presented, memory read in flight
   // S_LATCH | memory data valid, instruction register enabled
   // S_EXEC  | instruction valid, waiting for decoder event
   // S_HALT  | fetching stopped until clr
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LATCH, S_EXEC, S_HALT} state_t;

   state_t            state;
   logic              latch_q;
   logic [ADDR_W-1:0] pc_inc;

`ifdef PC_CALL_STACK_EN
   logic [ADDR_W-1:0] ret_addr;
   logic              ret_full;
`endif

   // pm_addr is the PC itself; no separate copy is kept.
   assign pc_inc = pm_addr + ADDR_W'(1);

   // Gating with stall keeps the pulse deferred while LATCH is held; clearing
   // latch_q asynchronously drops ir_ce the moment clr rises.
   assign ir_ce = latch_q & ~stall;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state       <= S_IDLE;
         pm_addr     <= RESET_PC;
         latch_q     <= 1'b0;
         fetch_valid <= 1'b0;
         halted      <= 1'b0;
`ifdef PC_CALL_STACK_EN
         ret_addr    <= '0;
         ret_full    <= 1'b0;
         stack_err   <= 1'b0;
`endif
      end else if (!stall) begin
         case (state)
            S_IDLE: begin
               if (run) state <= S_ADDR;
            end
            S_ADDR: begin
               state   <= S_LATCH;
               latch_q <= 1'b1;
            end
            S_LATCH: begin
               state       <= S_EXEC;
               latch_q     <= 1'b0;
               fetch_valid <= 1'b1;
            end
            S_EXEC: begin
               if (halt) begin
                  state       <= S_HALT;
                  fetch_valid <= 1'b0;
                  halted      <= 1'b1;
               end
`ifdef PC_CALL_STACK_EN
               else if (call) begin
                  pm_addr     <= jmp_addr;
                  ret_addr    <= pc_inc;
                  ret_full    <= 1'b1;
                  if (ret_full) stack_err <= 1'b1;
                  state       <= S_ADDR;
                  fetch_valid <= 1'b0;
               end else if (ret) begin
                  pm_addr     <= ret_addr;
                  ret_full    <= 1'b0;
                  if (!ret_full) stack_err <= 1'b1;
                  state       <= S_ADDR;
                  fetch_valid <= 1'b0;
               end
`endif
               else if (jmp || (bz && zero_flag)) begin
                  pm_addr     <= jmp_addr;
                  state       <= S_ADDR;
                  fetch_valid <= 1'b0;
               end else if (bz || exec_done) begin
                  pm_addr     <= pc_inc;
                  state       <= S_ADDR;
                  fetch_valid <= 1'b0;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state       <= S_IDLE;
               latch_q     <= 1'b0;
               fetch_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Scoreboard bench for pc_fetch_seq: expected fetch addresses are queued by the
// stimulus and popped by a monitor on every ir_ce pulse.
module tb_pc_fetch_seq;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          clr, run, stall, exec_done, jmp, bz, zero_flag, halt;
   logic [AW-1:0] jmp_addr;
   logic [AW-1:0] pm_addr;
   logic          ir_ce, fetch_valid, halted;

   int            vectors = 0;
   int            miscompares = 0;
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] model_pc;
   logic          prev_ce = 1'b0;

   always #5 clk = ~clk;

   pc_fetch_seq #(.ADDR_W(AW), .RESET_PC('0)) dut (
      .clk(clk), .clr(clr), .run(run), .stall(stall), .exec_done(exec_done),
      .jmp(jmp), .bz(bz), .zero_flag(zero_flag), .jmp_addr(jmp_addr),
      .halt(halt), .pm_addr(pm_addr), .ir_ce(ir_ce),
      .fetch_valid(fetch_valid), .halted(halted)
   );

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every ir_ce pulse must present the next queued address.
   always @(negedge clk) begin
      if (clr) begin
         prev_ce <= 1'b0;
      end else begin
         chk("ce_fv_exclusive", int'(ir_ce & fetch_valid), 0);
         if (prev_ce) chk("fv_after_ce", fetch_valid, 1);
         if (ir_ce) begin
            if (exp_q.size() == 0) chk("unexpected_ir_ce", 1, 0);
            else chk("pm_addr_at_ce", pm_addr, exp_q.pop_front());
         end
         prev_ce <= ir_ce;
      end
   end

   // Called at a negedge in EXEC; returns at the following negedge (ADDR).
   task automatic fetch_event(input logic j, input logic b, input logic z,
                              input logic e, input logic [AW-1:0] a);
      logic [AW-1:0] nxt;
      if (j)      nxt = a;
      else if (b) nxt = z ? a : AW'(model_pc + 1);
      else        nxt = AW'(model_pc + 1);
      jmp = j; bz = b; zero_flag = z; exec_done = e; jmp_addr = a;
      model_pc = nxt;
      exp_q.push_back(nxt);
      @(posedge clk);
      #1 jmp = 0; bz = 0; zero_flag = 0; exec_done = 0;
      @(negedge clk);
      chk("addr_phase_pm", pm_addr, nxt);
      chk("addr_phase_ce", ir_ce, 0);
      chk("addr_phase_fv", fetch_valid, 0);
   endtask

   task automatic wait_exec(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fetch_valid && n < 20);
      if (!fetch_valid) chk("exec_timeout", 0, 1);
   endtask

   initial begin
      int n;
      logic [2:0] bits;
      clr = 1; run = 0; stall = 0; exec_done = 0; jmp = 0; bz = 0;
      zero_flag = 0; halt = 0; jmp_addr = '0;
      #12;
      chk("rst_pm_addr", pm_addr, 0);
      chk("rst_ir_ce", ir_ce, 0);
      chk("rst_fv", fetch_valid, 0);
      chk("rst_halted", halted, 0);

      // Sequential fetch 0,1,2,3 at one instruction per 3 cycles.
      @(negedge clk);
      clr = 0; run = 1; model_pc = '0; exp_q.push_back('0);
      wait_exec(n);
      for (int i = 0; i < 3; i++) begin
         fetch_event(0, 0, 0, 1, AW'($urandom));
         wait_exec(n);
         chk("seq_period", n, 2);
      end
      run = 0;
      chk("seq_pc3", pm_addr, 3);

      // Jump, untaken branch, taken branch.
      fetch_event(1, 0, 0, 0, 8'h2A); wait_exec(n);
      fetch_event(0, 1, 0, 0, 8'h10); wait_exec(n);
      chk("bz_untaken", pm_addr, 8'h2B);
      fetch_event(0, 1, 1, 0, 8'h10); wait_exec(n);
      chk("bz_taken", pm_addr, 8'h10);

      // Wrap at the top of the address space.
      fetch_event(1, 0, 0, 0, 8'hFF); wait_exec(n);
      fetch_event(0, 0, 0, 1, 8'h33); wait_exec(n);
      chk("wrap_pc", pm_addr, 0);

      // Stall entered in LATCH for 4 cycles.
      fetch_event(0, 0, 0, 1, 8'h00);
      @(posedge clk);
      #1 stall = 1;
      repeat (4) begin
         @(negedge clk);
         chk("stall_ce", ir_ce, 0);
         chk("stall_pc", pm_addr, model_pc);
      end
      @(posedge clk);
      #1 stall = 0;
      @(negedge clk);
      chk("ce_after_stall", ir_ce, 1);
      wait_exec(n);

      // Stall in EXEC masks decoder pulses.
      stall = 1; exec_done = 1; jmp = 1; jmp_addr = 8'h99;
      repeat (3) begin
         @(negedge clk);
         chk("stall_exec_fv", fetch_valid, 1);
         chk("stall_exec_pc", pm_addr, model_pc);
      end
      stall = 0; exec_done = 0; jmp = 0;
      @(negedge clk);
      chk("exec_hold_fv", fetch_valid, 1);

      // Randomized events, including simultaneous pulses.
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("exec_idle_fv", fetch_valid, 1);
            chk("exec_idle_pc", pm_addr, model_pc);
         end
         bits = 3'($urandom_range(1, 7));
         fetch_event(bits[0], bits[1], 1'($urandom), bits[2], AW'($urandom));
         wait_exec(n);
      end

      // halt wins over jmp; nothing restarts the sequencer.
      halt = 1; jmp = 1; jmp_addr = 8'h55;
      @(posedge clk);
      #1 halt = 0; jmp = 0;
      @(negedge clk);
      chk("halt_flag", halted, 1);
      chk("halt_fv", fetch_valid, 0);
      chk("halt_pc", pm_addr, model_pc);
      run = 1; exec_done = 1;
      repeat (8) begin
         @(negedge clk);
         chk("halt_hold", halted, 1);
         chk("halt_hold_pc", pm_addr, model_pc);
         chk("halt_no_ce", ir_ce, 0);
      end
      exec_done = 0;

      // clr exits HALT, then clr again in the middle of an ir_ce pulse.
      clr = 1;
      @(negedge clk);
      chk("clr_exit_halt", halted, 0);
      clr = 0; model_pc = '0; exp_q.push_back('0);
      wait_exec(n);
      fetch_event(1, 0, 0, 0, 8'h77);
      @(negedge clk);
      chk("latch_ce", ir_ce, 1);
      #2 clr = 1; run = 0;
      #1;
      chk("clr_async_ce", ir_ce, 0);
      chk("clr_async_pc", pm_addr, 0);
      chk("clr_async_fv", fetch_valid, 0);
      @(negedge clk);
      @(negedge clk);
      clr = 0; model_pc = '0;
      repeat (5) begin
         @(negedge clk);
         chk("idle_ce", ir_ce, 0);
         chk("idle_fv", fetch_valid, 0);
         chk("idle_pc", pm_addr, 0);
      end
      run = 1; exp_q.push_back('0);
      wait_exec(n);
      chk("restart_pc", pm_addr, 0);

      @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
- Program-counter and fetch sequencer directly upstream of the 4-bit instruction/operand register (ce-gated D register with async clear).
- Generates program-memory address `pm_addr` and drives the register's `ce` via `ir_ce`, one pulse per fetched nibble.
- Handles sequential increment, absolute jump, conditional branch on zero, stall and halt for the 4-bit micro-processor datapath.

Parameters:
- ADDR_W, 8, program-memory address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on clr.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- run  input  1  level; leaves IDLE when 1.
- stall  input  1  holds sequencer in current state, no PC change, ir_ce forced 0.
- exec_done  input  1  decoder pulse: current instruction finished, advance sequentially.
- jmp  input  1  decoder pulse: unconditional jump to jmp_addr.
- bz  input  1  decoder pulse: branch to jmp_addr if zero_flag=1, else sequential.
- zero_flag  input  1  ALU zero flag, sampled with bz.
- jmp_addr  input  ADDR_W  jump/branch target.
- halt  input  1  decoder pulse: stop fetching.
- pm_addr  output  ADDR_W  program-memory address (registered; equals PC).
- ir_ce  output  1  clock enable to instruction register; one-cycle pulse.
- fetch_valid  output  1  1 in EXEC: instruction register holds a valid nibble.
- halted  output  1  1 in HALT state.

Behaviour:
- Reset (clr=1, async): state=IDLE, PC=RESET_PC, pm_addr=RESET_PC, ir_ce=0, fetch_valid=0, halted=0.
- States: IDLE, ADDR, LATCH, EXEC, HALT.
- IDLE: run=1 -> ADDR. Otherwise stay.
- ADDR: pm_addr=PC for one cycle; program memory is synchronous with 1-cycle read latency. Next state LATCH.
- LATCH: ir_ce=1 this cycle only; the register captures pm data at the end of the cycle. Next state EXEC.
- EXEC: fetch_valid=1. Event priority in one cycle: halt > jmp > bz > exec_done.
  - halt -> HALT.
  - jmp -> PC=jmp_addr, then ADDR.
  - bz with zero_flag=1 -> PC=jmp_addr, then ADDR.
  - bz with zero_flag=0 -> PC=PC+1, then ADDR.
  - exec_done -> PC=PC+1, then ADDR.
  - None of these -> stay in EXEC.
- HALT: halted=1, PC frozen. Only clr exits.
- Fetch latency: 2 cycles from entering ADDR to fetch_valid=1. Minimum instruction period is 3 cycles.
- Arithmetic: PC+1 is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0 with no flag.
- stall=1 in any state: state, PC and pm_addr hold; ir_ce=0. Any event pulses in EXEC are ignored (the decoder must not pulse while stalling). A stall in LATCH delays the ir_ce pulse until stall deasserts.
- run=0 is sampled only in IDLE; dropping run mid-program has no effect.
- clr mid-operation: immediate return to reset values, including during an ir_ce pulse. ir_ce drops asynchronously.
- ir_ce and fetch_valid are never 1 in the same cycle.

Optional Feature:
- Macro: PC_CALL_STACK_EN.
- With the macro defined, adds ports:
  - call (input 1): as jmp, and also saves PC+1 into a 1-deep return register.
  - ret (input 1): PC=return register, then ADDR.
  - stack_err (output 1, sticky until clr): set on a call while the return register is already full, or on a ret while it is empty.
  - EXEC priority becomes halt > call > ret > jmp > bz > exec_done.
  - The return register resets to empty.
- Without the macro, none of these ports or registers exist; behaviour is as above.

Test Plan:
- Reset then run=1, exec_done each EXEC -> pm_addr sequence 0,1,2,3; ir_ce pulses exactly once per 3 cycles; fetch_valid 1 cycle after each ir_ce.
- ADDR_W=4, PC=15, exec_done -> pm_addr=0, no glitch, normal fetch continues.
- EXEC with jmp=1, jmp_addr=0x2A -> next ADDR shows pm_addr=0x2A. Then bz=1, zero_flag=0 at PC 0x2A -> pm_addr=0x2B. Then bz=1, zero_flag=1, jmp_addr=0x10 -> pm_addr=0x10.
- halt and jmp asserted together in EXEC -> HALT, halted=1, pm_addr unchanged, no further ir_ce; further run or exec_done ignored.
- stall=1 for 4 cycles entered in LATCH -> ir_ce held 0 for 4 cycles, then one pulse; PC unchanged.
- clr asserted mid-LATCH (asynchronously) -> ir_ce=0 and pm_addr=RESET_PC immediately; state IDLE until run=1.
